aurora_reset_seq: RTL

Reset and link-supervision sequencer for the Aurora 64B66B core, running in the init-clock domain directly upstream of the Aurora wrapper's `pma_init`/`reset_pb` inputs. It holds the core in reset after `pcie_reset`, then releases `pma_init` and `reset_pb` in the required order. It watches a synchronised `channel_up` and restarts the full sequence on link-up timeout, link loss or a software retrain request, counting the retries.

---
 rtl/aurora_reset_seq_pkg.sv | 18 +
 rtl/aurora_reset_seq_sync_2ff.sv | 15 +
 rtl/aurora_reset_seq.sv | 75 +++++++
 3 files changed

// File: rtl/aurora_reset_seq_pkg.sv
// aurora_reset_seq_pkg: state encoding, default cycle constants and helpers for the Aurora reset sequencer
package aurora_reset_seq_pkg;
   typedef enum logic [2:0] {
      PB_ASSERT  = 3'd0,
      PMA_HOLD   = 3'd1,
      PB_RELEASE = 3'd2,
      WAIT_LINK  = 3'd3,
      LINK_UP    = 3'd4
   } state_t;
   localparam int DEF_PMA_HOLD_CYCLES     = 134217727;
   localparam int DEF_PB_LEAD_CYCLES      = 128;
   localparam int DEF_LINK_TIMEOUT_CYCLES = 268435455;
   localparam int DEF_DROP_FILTER_CYCLES  = 16;
   localparam int DEF_CNT_W               = 28;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/aurora_reset_seq_sync_2ff.sv
// sync_2ff: two-flop synchroniser with selectable reset value
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic INIT_CLK_i,
   input  logic pcie_reset,
   input  logic d_i,
   output logic q_o
);
   logic meta;
   // shift the asynchronous input through two flops
   always_ff @(posedge INIT_CLK_i or posedge pcie_reset)
      if (pcie_reset) {q_o, meta} <= {2{RST_VAL}};
      else            {q_o, meta} <= {meta, d_i};
endmodule

// File: rtl/aurora_reset_seq.sv
// aurora_reset_seq: ordered pma_init/reset_pb sequencing with link supervision and retry counting
module aurora_reset_seq
   import aurora_reset_seq_pkg::*;
#(
   parameter int PMA_HOLD_CYCLES     = DEF_PMA_HOLD_CYCLES,
   parameter int PB_LEAD_CYCLES      = DEF_PB_LEAD_CYCLES,
   parameter int LINK_TIMEOUT_CYCLES = DEF_LINK_TIMEOUT_CYCLES,
   parameter int DROP_FILTER_CYCLES  = DEF_DROP_FILTER_CYCLES,
   parameter int CNT_W               = DEF_CNT_W
) (
   input  logic       INIT_CLK_i,
   input  logic       pcie_reset,
   input  logic       channel_up_i,
   input  logic       force_retrain_i,
   output logic       pma_init,
   output logic       reset_pb,
   output logic       link_up_o,
   output logic       seq_busy_o,
   output logic [7:0] retry_cnt_o
);
   localparam logic [CNT_W-1:0] PMA_LAST = CNT_W'(PMA_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PB_LAST  = CNT_W'(PB_LEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DF_LAST  = CNT_W'(DROP_FILTER_CYCLES - 1);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       retry_n;
   logic             ch_up_s, pma_n, pb_n, link_n;
   sync_2ff #(.RST_VAL(1'b0)) u_sync (
      .INIT_CLK_i (INIT_CLK_i),
      .pcie_reset (pcie_reset),
      .d_i        (channel_up_i),
      .q_o        (ch_up_s)
   );
   // next state, counter, retry count and the outputs of the state being entered
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      retry_n = retry_cnt_o;
      case (state)
         PB_ASSERT:  if (cnt == PB_LAST) state_n = PMA_HOLD;
         PMA_HOLD:   if (cnt == PMA_LAST) state_n = PB_RELEASE;
         PB_RELEASE: if (cnt == PB_LAST) state_n = WAIT_LINK;
         WAIT_LINK:  if (force_retrain_i || (!ch_up_s && cnt == TO_LAST)) state_n = PB_ASSERT;
                     else if (ch_up_s) state_n = LINK_UP;
         LINK_UP:    if (force_retrain_i || (!ch_up_s && cnt == DF_LAST)) state_n = PB_ASSERT;
                     else cnt_n = ch_up_s ? '0 : cnt + 1'b1;
         default:    state_n = PMA_HOLD;
      endcase
      if (state_n != state) cnt_n = '0;
      if (state_n == PB_ASSERT && state != PB_ASSERT) retry_n = sat_inc(retry_cnt_o);
      pma_n  = state_n == PMA_HOLD;
      pb_n   = state_n inside {PB_ASSERT, PMA_HOLD, PB_RELEASE};
      link_n = state_n == LINK_UP;
   end
   // state, counter and registered outputs; reset parks the core in PMA_HOLD
   always_ff @(posedge INIT_CLK_i or posedge pcie_reset)
      if (pcie_reset) begin
         state       <= PMA_HOLD;
         cnt         <= '0;
         retry_cnt_o <= 8'd0;
         pma_init    <= 1'b1;
         reset_pb    <= 1'b1;
         seq_busy_o  <= 1'b1;
         link_up_o   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         retry_cnt_o <= retry_n;
         pma_init    <= pma_n;
         reset_pb    <= pb_n;
         seq_busy_o  <= pb_n;
         link_up_o   <= link_n;
      end
endmodule
